// File: rtl/qsys_mm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qsys_mm_arbiter
// Purpose  : Shares one Avalon-MM slave port between NUM_MASTERS masters.
//            One master is granted at a time and its write/read command is
//            forwarded to the slave. Read responses are routed back to the
//            issuing master through an in-order tag FIFO.
// Build    : QSYS_ARB_FIXED_PRIO_EN defined   -> fixed priority (lowest
//                                                 index requester wins)
//            QSYS_ARB_FIXED_PRIO_EN undefined -> round-robin (default)
// Ports    : clk, rst             - clock, synchronous active-high reset
//            m_writedata/m_address - packed per-master command fields
//            m_write/m_read        - per-master command strobes
//            m_waitrequest         - per-master stall (low on acceptance)
//            m_readdata            - broadcast copy of s_readdata
//            m_readdatavalid       - one-hot response strobe
//            s_*                   - slave command, response and stall
//            err_unexpected        - sticky: response with no read pending
// Revision : 1.0 - initial release
// ============================================================================
module qsys_mm_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*WIDTH-1:0]      m_writedata,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS-1:0]            m_read,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [WIDTH-1:0]                  m_readdata,
  output logic [NUM_MASTERS-1:0]            m_readdatavalid,
  output logic [WIDTH-1:0]                  s_writedata,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic                              s_write,
  output logic                              s_read,
  input  logic [WIDTH-1:0]                  s_readdata,
  input  logic                              s_readdatavalid,
  input  logic                              s_waitrequest,
  output logic                              err_unexpected
);

  localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int c_PTR_W = $clog2(MAX_PENDING);
  localparam int c_CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_PENDING);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   grant_q, grant_d;
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic [c_IDX_W-1:0]   tag_mem_q [MAX_PENDING];

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_any_req;
  logic [c_IDX_W-1:0]     w_pick;
  logic                   w_busy;
  logic                   w_full;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_has_tag;

  logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_MASTERS];
  logic [WIDTH-1:0]       w_wdata_arr [NUM_MASTERS];

  // Unpack the flat per-master buses so the granted master can be selected
  // with a plain array index.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[gi] = m_writedata[gi*WIDTH +: WIDTH];
  end

  assign w_req     = m_write | m_read;
  assign w_any_req = |w_req;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef QSYS_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest-index requester is the last to overwrite.
  always_comb begin
    w_pick = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (w_req[j]) begin
        w_pick = c_IDX_W'(j);
      end
    end
  end
`else
  logic [c_IDX_W-1:0] last_grant_q, last_grant_d;
  logic [c_IDX_W-1:0] w_cand;
  logic               w_found;

  // Search starts one past the previous winner and wraps modulo NUM_MASTERS.
  always_comb begin
    w_pick  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      w_cand = c_IDX_W'((int'(last_grant_q) + 1 + j) % NUM_MASTERS);
      if (!w_found && w_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && w_any_req) begin
      last_grant_d = w_pick;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= c_IDX_W'(NUM_MASTERS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Command path
  // --------------------------------------------------------------------------
  assign w_busy = (state_q == ST_BUSY);
  // Fullness is taken from the registered count, so a same-cycle pop does
  // not release a blocked read until the following cycle.
  assign w_full = (count_q == c_FULL);

  assign s_write     = w_busy & m_write[grant_q];
  assign s_read      = w_busy & m_read[grant_q] & ~w_full;
  assign s_address   = w_addr_arr[grant_q];
  assign s_writedata = w_wdata_arr[grant_q];
  assign w_accept    = (s_write | s_read) & ~s_waitrequest;

  always_comb begin
    m_waitrequest = '1;
    if (w_accept) begin
      m_waitrequest[grant_q] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          grant_d = w_pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Response tag FIFO
  // --------------------------------------------------------------------------
  assign w_push    = w_accept & s_read;
  assign w_has_tag = (count_q != '0);
  assign w_pop     = s_readdatavalid & w_has_tag;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_W'(1);
    end
    err_d = err_q | (s_readdatavalid & ~w_has_tag);
  end

  assign m_readdata = s_readdata;

  always_comb begin
    m_readdatavalid = '0;
    if (w_pop) begin
      m_readdatavalid[tag_mem_q[rd_ptr_q]] = 1'b1;
    end
  end

  assign err_unexpected = err_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q > 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      tag_mem_q[wr_ptr_q] <= grant_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qsys_mm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qsys_mm_arbiter
// Purpose  : Directed, table-driven check of qsys_mm_arbiter (2 masters,
//            32-bit data/address, 4 outstanding reads, round-robin build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qsys_mm_arbiter;

  localparam int NM = 2;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int MP = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM*W-1:0]  m_writedata;
  logic [NM*AW-1:0] m_address;
  logic [NM-1:0]    m_write;
  logic [NM-1:0]    m_read;
  logic [NM-1:0]    m_waitrequest;
  logic [W-1:0]     m_readdata;
  logic [NM-1:0]    m_readdatavalid;
  logic [W-1:0]     s_writedata;
  logic [AW-1:0]    s_address;
  logic             s_write;
  logic             s_read;
  logic [W-1:0]     s_readdata;
  logic             s_readdatavalid;
  logic             s_waitrequest;
  logic             err_unexpected;

  always #5 clk = ~clk;

  qsys_mm_arbiter #(
    .NUM_MASTERS (NM),
    .WIDTH       (W),
    .ADDR_WIDTH  (AW),
    .MAX_PENDING (MP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .m_writedata     (m_writedata),
    .m_address       (m_address),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_writedata     (s_writedata),
    .s_address       (s_address),
    .s_write         (s_write),
    .s_read          (s_read),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .s_waitrequest   (s_waitrequest),
    .err_unexpected  (err_unexpected)
  );

  // Master 0 always presents 0x10 / 0xA5A5A5A5, master 1 0x20 / 0x5A5A5A5A.
  localparam logic [31:0] c_A0 = 32'h10;
  localparam logic [31:0] c_A1 = 32'h20;
  localparam logic [31:0] c_D0 = 32'hA5A5A5A5;
  localparam logic [31:0] c_D1 = 32'h5A5A5A5A;

  typedef struct {
    logic [1:0]  mw;
    logic [1:0]  mr;
    logic        swait;
    logic        srv;
    logic [31:0] srdata;
    logic        ew;
    logic        er;
    logic [1:0]  ewait;
    logic [1:0]  erdv;
    logic [31:0] eaddr;
    logic        eerr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [1:0] mw, input logic [1:0] mr,
                              input logic swait, input logic srv,
                              input logic [31:0] srdata, input logic ew,
                              input logic er, input logic [1:0] ewait,
                              input logic [1:0] erdv, input logic [31:0] eaddr,
                              input logic eerr);
    vec_t v;
    v.mw = mw; v.mr = mr; v.swait = swait; v.srv = srv; v.srdata = srdata;
    v.ew = ew; v.er = er; v.ewait = ewait; v.erdv = erdv; v.eaddr = eaddr;
    v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, check the settled
  // outputs 1 ns later, then advance to the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    m_write         = v.mw;
    m_read          = v.mr;
    s_waitrequest   = v.swait;
    s_readdatavalid = v.srv;
    s_readdata      = v.srdata;
    #1;
    check({tag, " s_write"}, 32'(s_write), 32'(v.ew));
    check({tag, " s_read"}, 32'(s_read), 32'(v.er));
    check({tag, " m_waitrequest"}, 32'(m_waitrequest), 32'(v.ewait));
    check({tag, " m_readdatavalid"}, 32'(m_readdatavalid), 32'(v.erdv));
    check({tag, " err_unexpected"}, 32'(err_unexpected), 32'(v.eerr));
    if (v.ew || v.er) begin
      check({tag, " s_address"}, s_address, v.eaddr);
    end
    if (v.ew) begin
      check({tag, " s_writedata"}, s_writedata, (v.eaddr == c_A0) ? c_D0 : c_D1);
    end
    if (v.erdv != 2'b00) begin
      check({tag, " m_readdata"}, m_readdata, v.srdata);
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    m_address       = {c_A1, c_A0};
    m_writedata     = {c_D1, c_D0};
    m_write         = '0;
    m_read          = '0;
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;

    //             mw     mr     sw   srv  srdata  ew   er   ewait  erdv   eaddr eerr
    // reset state
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    // single write from master 0
    tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b10, 2'b00, c_A0,  1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    // contention after master 0 won: 1,0,1
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b01, 2'b00, c_A1,  1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b10, 2'b00, c_A0,  1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b01, 2'b00, c_A1,  1'b0));
    // master 1 write stalled 3 cycles by the slave
    tbl.push_back(mk(2'b10, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 2'b11, 2'b00, c_A1,  1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 2'b11, 2'b00, c_A1,  1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 2'b11, 2'b00, c_A1,  1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b01, 2'b00, c_A1,  1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    // read ordering: master 0 then master 1, responses 0x11 then 0x22
    tbl.push_back(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 2'b10, 2'b00, c_A0,  1'b0));
    tbl.push_back(mk(2'b00, 2'b10, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b10, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 2'b01, 2'b00, c_A1,  1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 2'b11, 2'b01, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 2'b11, 2'b10, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0));

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // FIFO full: four reads from master 0 fill the tag FIFO.
    for (int k = 0; k < MP; k++) begin
      apply(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), $sformatf("fill%0d_idle", k));
      apply(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 2'b00, c_A0,  1'b0), $sformatf("fill%0d_acc", k));
    end
    // Fifth read is granted but blocked while the count is at its limit,
    // including the cycle in which the first response pops.
    apply(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "full_idle");
    apply(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "full_block0");
    apply(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "full_block1");
    apply(mk(2'b00, 2'b01, 1'b0, 1'b1, 32'hC0, 1'b0, 1'b0, 2'b11, 2'b01, 32'h0, 1'b0), "full_pop");
    apply(mk(2'b00, 2'b01, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 2'b10, 2'b00, c_A0,  1'b0), "full_acc5");
    apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "full_done");

    // Drain the four outstanding tags, then an unexpected response.
    for (int k = 0; k < MP; k++) begin
      apply(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hD0 + 32'(k), 1'b0, 1'b0, 2'b11, 2'b01, 32'h0, 1'b0), $sformatf("drain%0d", k));
    end
    apply(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hEE, 1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "unexp_rsp");
    apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b1), "err_set");
    apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b1), "err_hold");

    // Leave a tag pending for master 1 and a write in flight, then reset.
    apply(mk(2'b00, 2'b10, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b1), "pre_rst_idle");
    apply(mk(2'b00, 2'b10, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 2'b01, 2'b00, c_A1,  1'b1), "pre_rst_rd");
    apply(mk(2'b01, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b1), "pre_rst_wr");
    m_write = 2'b01;
    pulse_reset();
    apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "post_rst");
    // The pending tag was discarded, so this response is unexpected.
    apply(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "post_rst_rsp");
    apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b1), "post_rst_err");
    pulse_reset();
    apply(mk(2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "err_clr");
    // After reset master 0 wins first, then master 1.
    apply(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "rr0_idle");
    apply(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b10, 2'b00, c_A0,  1'b0), "rr0_acc");
    apply(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 2'b11, 2'b00, 32'h0, 1'b0), "rr1_idle");
    apply(mk(2'b11, 2'b00, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 2'b01, 2'b00, c_A1,  1'b0), "rr1_acc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
